// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: datapath width, canonical NOP and the
// fetch packet carried from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF/ID queue: one synchronous write port and one
// combinational read port. The array has no reset; validity lives in the control.
module ifq_storage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  fetch_pkt_t               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output fetch_pkt_t               rd_data
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with flush on branch redirect.
// Define IF_ID_QUEUE_BYPASS_EN to forward fetch straight to decode when empty.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          pc_f,
  input  logic [XLEN-1:0]          instr_f,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic                     flush,
  output logic [XLEN-1:0]          pc_d,
  output logic [XLEN-1:0]          instr_d,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic          do_write;
  logic          do_read;
  fetch_pkt_t    wr_pkt;
  fetch_pkt_t    head_pkt;

  assign empty = (count_q == '0);

  // Bypass is gated by reset so outputs stay idle while reset is held.
`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = reset && empty && f_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign f_ready     = (count_q != CW'(DEPTH));
  assign d_valid     = !empty || bypass;
  assign push        = f_valid && f_ready;
  assign pop         = d_valid && d_ready;
  assign bypass_take = bypass && d_ready;
  assign do_write    = push && !flush && !bypass_take;
  assign do_read     = pop && !flush && !bypass_take;
  assign count       = count_q;

  assign wr_pkt.pc    = pc_f;
  assign wr_pkt.instr = instr_f;

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (do_write),
    .wr_addr (wr_ptr),
    .wr_data (wr_pkt),
    .rd_addr (rd_ptr),
    .rd_data (head_pkt)
  );

  always_comb begin
    pc_d    = '0;
    instr_d = NOP_INSTR;
    if (!empty) begin
      pc_d    = head_pkt.pc;
      instr_d = head_pkt.instr;
    end else if (bypass) begin
      pc_d    = pc_f;
      instr_d = instr_f;
    end
  end

  // Flush outranks any push or pop requested in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH = 4); expectations
// follow IF_ID_QUEUE_BYPASS_EN when that macro is defined.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        f_valid;
  logic        f_ready;
  logic        flush;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  count;

  int tests    = 0;
  int failures = 0;

  if_id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .pc_f    (pc_f),
    .instr_f (instr_f),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .flush   (flush),
    .pc_d    (pc_d),
    .instr_d (instr_d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
    f_valid = fv;
    pc_f    = pc;
    instr_f = instr_of(pc);
    d_ready = dr;
    flush   = fl;
  endtask

  initial begin
    logic [31:0] sb[$];
    logic [31:0] next_pc;
    int          mcount;
    int          pushed;
    int          popped;
    int          cycles;
    logic        fv;
    logic        dr;
    logic        byp;
    logic        exp_fr;
    logic        exp_dv;
    logic [31:0] cur_pc;
    logic [31:0] exp_pc;
    logic        bypass_build;

`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif

    // Reset state
    reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check_output("rst_count",   32'(count),   32'd0);
    check_output("rst_f_ready", 32'(f_ready), 32'd1);
    check_output("rst_d_valid", 32'(d_valid), 32'd0);
    check_output("rst_pc_d",    pc_d,         32'h0);
    check_output("rst_instr_d", instr_d,      NOP);
    tick();
    reset = 1'b1;

    // Fill and stall
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 32'(4 * i), 1'b0, 1'b0);
      #1;
      check_output("fill_f_ready", 32'(f_ready), 32'd1);
      tick();
    end
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0);
    #1;
    check_output("full_f_ready", 32'(f_ready), 32'd0);
    check_output("full_count",   32'(count),   32'd4);
    check_output("full_d_valid", 32'(d_valid), 32'd1);
    check_output("full_pc_d",    pc_d,         32'h0);
    tick();
    check_output("full_no_accept", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check_output("drain_d_valid", 32'(d_valid), 32'd1);
      check_output("drain_pc_d",    pc_d,         32'(4 * i));
      check_output("drain_instr_d", instr_d,      instr_of(32'(4 * i)));
      tick();
      if (i == 0) begin
        check_output("unfull_f_ready", 32'(f_ready), 32'd1);
        check_output("unfull_count",   32'(count),   32'd3);
      end
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("empty_count",   32'(count),   32'd0);
    check_output("empty_d_valid", 32'(d_valid), 32'd0);
    check_output("empty_pc_d",    pc_d,         32'h0);
    check_output("empty_instr_d", instr_d,      NOP);

    // Streaming
    next_pc = 32'h100;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      #1;
      check_output("stream_d_valid", 32'(d_valid), 32'(bypass_build || (i > 0)));
      if (d_valid) begin
        check_output("stream_pc_d", pc_d, next_pc);
        next_pc = next_pc + 32'd4;
      end
      tick();
      check_output("stream_count", 32'(count), bypass_build ? 32'd0 : 32'd1);
    end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    if (d_valid) begin
      check_output("stream_tail_pc_d", pc_d, next_pc);
      next_pc = next_pc + 32'd4;
    end
    tick();
    check_output("stream_all_seen", next_pc, 32'h150);
    check_output("stream_end_count", 32'(count), 32'd0);

    // Flush with a simultaneous push and pop request
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    check_output("preflush_count", 32'(count), 32'd3);
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("flush_count",   32'(count),   32'd0);
    check_output("flush_d_valid", 32'(d_valid), 32'd0);
    check_output("flush_pc_d",    pc_d,         32'h0);
    apply_stimulus(1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("postflush_count", 32'(count), 32'd1);
    check_output("postflush_pc_d",  pc_d,       32'h500);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_output("postflush_drained", 32'(count), 32'd0);

    // Wrap-around with random decode back-pressure
    mcount = 0;
    pushed = 0;
    popped = 0;
    cycles = 0;
    while (popped < 3 * DEPTH && cycles < 300) begin
      fv     = (pushed < 3 * DEPTH);
      dr     = 1'($urandom_range(0, 1));
      cur_pc = 32'h600 + 32'(4 * pushed);
      apply_stimulus(fv, cur_pc, dr, 1'b0);
      #1;
      exp_fr = (mcount != DEPTH);
      byp    = bypass_build && (mcount == 0) && fv;
      exp_dv = (mcount != 0) || byp;
      check_output("wrap_f_ready", 32'(f_ready), 32'(exp_fr));
      check_output("wrap_d_valid", 32'(d_valid), 32'(exp_dv));
      if (exp_dv && dr) begin
        exp_pc = (mcount == 0) ? cur_pc : sb[0];
        check_output("wrap_pc_d", pc_d, exp_pc);
      end
      if (byp && dr) begin
        pushed++;
        popped++;
      end else begin
        if (exp_dv && dr) begin
          void'(sb.pop_front());
          mcount--;
          popped++;
        end
        if (fv && exp_fr) begin
          sb.push_back(cur_pc);
          mcount++;
          pushed++;
        end
      end
      tick();
      check_output("wrap_count", 32'(count), 32'(mcount));
      cycles++;
    end
    if (cycles >= 300) check_output("wrap_timeout", 32'(popped), 32'(3 * DEPTH));

    // Bypass versus registered latency
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b0);
    #1;
    check_output("byp_d_valid", 32'(d_valid), 32'(bypass_build));
    if (bypass_build) check_output("byp_pc_d", pc_d, 32'h40);
    tick();
    check_output("byp_count", 32'(count), bypass_build ? 32'd0 : 32'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    if (!bypass_build) begin
      check_output("lat_d_valid", 32'(d_valid), 32'd1);
      check_output("lat_pc_d",    pc_d,         32'h40);
    end
    tick();
    check_output("byp_end_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    check_output("prerst_count", 32'(count), 32'd3);
    apply_stimulus(1'b1, 32'h700, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check_output("midrst_count",   32'(count),   32'd0);
    check_output("midrst_d_valid", 32'(d_valid), 32'd0);
    check_output("midrst_instr_d", instr_d,      NOP);
    check_output("midrst_f_ready", 32'(f_ready), 32'd1);
    tick();
    check_output("midrst_hold_count",   32'(count),   32'd0);
    check_output("midrst_hold_d_valid", 32'(d_valid), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling instruction queue between the fetch stage and the decode stage. It captures each fetched (PC, instruction) pair, buffers up to DEPTH entries in order, and presents the oldest one to decode through a valid/ready handshake. When decode stalls, fetch keeps running until the queue fills. A branch redirect flushes every buffered entry, so no wrong-path instruction reaches decode.

## Interface
- DEPTH, 4: number of entries; must be a power of two, 2 to 16.
- XLEN, 32: width of PC and instruction.
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_f  input  XLEN  PC of the instruction offered by fetch.
- instr_f  input  XLEN  instruction offered by fetch.
- f_valid  input  1  fetch offers pc_f/instr_f this cycle.
- f_ready  output  1  queue accepts a push this cycle.
- flush  input  1  branch redirect; discard all entries.
- pc_d  output  XLEN  PC of the head entry.
- instr_d  output  XLEN  instruction of the head entry.
- d_valid  output  1  head entry is valid.
- d_ready  input  1  decode consumes the head entry this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: occurs when f_valid && f_ready. The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: occurs when d_valid && d_ready. The read pointer increments modulo DEPTH.
- f_ready = (count != DEPTH). It does not depend on d_ready, so there is no combinational ready path.
- d_valid = (count != 0), except where the bypass case applies (see Configuration).
- pc_d/instr_d are read combinationally from the head entry.
- When d_valid = 0, pc_d = 0 and instr_d = NOP_INSTR (32'h00000013).
- Count update:
  - push only: count + 1
  - pop only: count - 1
  - push and pop together: count unchanged; both pointers advance
- Full and empty: count = DEPTH means full; count = 0 means empty. Occupancy comes from count, not from pointer equality. Each pointer is $clog2(DEPTH) bits and wraps naturally.
- Flush:
  - On the next edge, count and both pointers return to 0.
  - A push or pop requested in the same cycle is discarded. Fetch must re-present the redirected PC.
  - flush has priority over every other event.
- Entry storage is not cleared on reset or flush; only the pointers and count are.
- Invariants: overflow and underflow cannot occur, because push is gated by f_ready and pop by d_valid.

## Timing
- Reset (reset = 0, asynchronous): count = 0, f_ready = 1, d_valid = 0, pc_d = 0, instr_d = NOP_INSTR. These hold throughout the reset assertion.
- Reset release: synchronous use of reset is not required. The first push can be accepted on the first rising edge after release.
- Reset asserted mid-operation: all buffered entries are lost immediately, with no handshake completing.
- Latency without bypass: an entry pushed at edge N is visible on d_valid/pc_d/instr_d after edge N, and the earliest pop is in cycle N+1.
- Throughput: one push and one pop per cycle sustained once at least one entry is resident.
- Back-pressure: with d_ready = 0, f_ready falls after the edge that writes the DEPTH-th entry.
- Full queue with d_ready = 1: one pop that cycle. f_ready rises next cycle, so a push is never accepted on the same cycle as the pop that frees the slot.
- Flush at edge N: d_valid = 0 and count = 0 after edge N. A push in cycle N+1 is visible after edge N+1.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: when count = 0, f_valid = 1 and flush = 0, the queue forwards fetch to decode combinationally in the same cycle:
  - d_valid = 1, pc_d = pc_f, instr_d = instr_f.
  - If d_ready = 1, nothing is written and count stays 0.
  - If d_ready = 0, the entry is written normally.
- IF_ID_QUEUE_BYPASS_EN undefined: there is no combinational path from fetch to decode, and the minimum latency is one cycle as stated in Timing.

## Structure
- Shared package riscv_pkg holds XLEN, NOP_INSTR, and typedef fetch_pkt_t (struct: pc, instr). Storage holds fetch_pkt_t entries.
- Natural sub-module: ifq_storage, a DEPTH × fetch_pkt_t register array with one write port and a combinational read port. No reset on the array.
- Pointer, count, flush and handshake control stay in if_id_queue.

## Test plan
- Reset: assert reset = 0 mid-stream with 3 entries resident -> immediately count = 0, d_valid = 0, instr_d = 32'h00000013, f_ready = 1.
- Fill and stall: DEPTH = 4, d_ready = 0, push PCs 0x0, 0x4, 0x8, 0xC -> f_ready = 0 after the 4th edge. A 5th offer (PC 0x10) is not accepted. Then d_ready = 1 -> pops come out in order 0x0, 0x4, 0x8, 0xC.
- Streaming: f_valid = d_ready = 1 for 20 cycles from PC 0x100 -> no bubbles after the first entry. Decode sees 0x100 through 0x14C in order, and count stays at 1 (0 with bypass).
- Flush: 3 entries resident, flush = 1 with f_valid = 1 (PC 0x200) and d_ready = 1 -> next cycle count = 0, d_valid = 0. PC 0x200 is not enqueued and no pop is counted.
- Wrap-around: run 3 × DEPTH pushes and pops with random d_ready -> a scoreboard shows order preserved and count within 0..DEPTH throughout.
- Bypass (macro defined): empty queue, push PC 0x40 with d_ready = 1 -> same-cycle d_valid = 1, pc_d = 0x40, count stays 0. Without the macro, d_valid rises one cycle later.
